// File: rtl/bwt_seq_ctrl.sv
// Sequencing controller for the bwt transform core: loads one block from the
// input stream, supervises the sort, then drains the core to the output stream.
module bwt_seq_ctrl #(
   parameter int MAX_LEN      = 1023,
   parameter int SORT_TIMEOUT = 4096
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_s_valid,
   output logic       o_s_ready,
   input  logic [7:0] i_s_data,
   input  logic       i_s_last,
   output logic       o_m_valid,
   input  logic       i_m_ready,
   output logic [7:0] o_m_data,
   output logic       o_m_last,
   output logic       o_core_clr,
   output logic       o_core_en,
   output logic [9:0] o_core_adr,
   output logic [7:0] o_core_in,
   output logic [9:0] o_core_len,
   input  logic [7:0] i_core_out,
   input  logic       i_core_done,
   output logic       o_busy,
   output logic       o_err_timeout,
   output logic       o_err_ovf
);

   localparam int TW = $clog2(SORT_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CLR, S_LOAD, S_SORT, S_RD_ADDR, S_RD_CAP, S_EMIT
   } state_t;

   state_t          r_state;
   logic [9:0]      r_cnt;
   logic [9:0]      r_ri;
   logic [9:0]      r_len;
   logic [TW-1:0]   r_tcnt;
   logic [7:0]      r_mdata;
   logic            r_mlast;
   logic            r_clr;
   logic            r_eto;
   logic            r_eovf;

   logic            w_beat;
   logic [9:0]      w_cnt1;
   logic            w_end;
   logic            w_rd;

   assign w_beat = (r_state == S_LOAD) && i_s_valid;
   assign w_cnt1 = r_cnt + 10'd1;
   // A block ends on s_last or when the MAX_LEN-th byte arrives without it.
   assign w_end  = i_s_last || (w_cnt1 == 10'(MAX_LEN));
   assign w_rd   = (r_state == S_RD_ADDR) || (r_state == S_RD_CAP) || (r_state == S_EMIT);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_ri    <= '0;
         r_len   <= '0;
         r_tcnt  <= '0;
         r_mdata <= '0;
         r_mlast <= 1'b0;
         r_clr   <= 1'b0;
         r_eto   <= 1'b0;
         r_eovf  <= 1'b0;
      end else begin
         r_clr <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_s_valid) begin
                  r_state <= S_CLR;
                  r_clr   <= 1'b1;
               end
            end
            S_CLR: begin
               r_cnt   <= '0;
               r_len   <= '0;
               r_eto   <= 1'b0;
               r_eovf  <= 1'b0;
               r_state <= S_LOAD;
            end
            S_LOAD: begin
               if (w_beat) begin
                  r_cnt <= w_cnt1;
                  if (w_end) begin
                     r_len   <= w_cnt1;
                     r_eovf  <= ~i_s_last;
                     r_ri    <= '0;
                     r_tcnt  <= '0;
                     r_state <= (w_cnt1 == 10'd1) ? S_RD_ADDR : S_SORT;
                  end
               end
            end
            S_SORT: begin
               if (i_core_done) begin
                  r_ri    <= '0;
                  r_state <= S_RD_ADDR;
               end else if (r_tcnt == TW'(SORT_TIMEOUT - 1)) begin
                  r_eto   <= 1'b1;
                  r_state <= S_IDLE;
               end else begin
                  r_tcnt <= r_tcnt + 1'b1;
               end
            end
            S_RD_ADDR: r_state <= S_RD_CAP;
            S_RD_CAP: begin
               r_mdata <= i_core_out;
               r_mlast <= (r_ri == r_len - 10'd1);
               r_state <= S_EMIT;
            end
            S_EMIT: begin
               if (i_m_ready) begin
                  if (r_mlast) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_ri    <= r_ri + 10'd1;
                     r_state <= S_RD_ADDR;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Load strobes follow the handshake directly so the core sees en low in SORT.
   assign o_s_ready     = (r_state == S_LOAD);
   assign o_core_en     = w_beat;
   assign o_core_in     = w_beat ? i_s_data : 8'd0;
   assign o_core_adr    = (r_state == S_LOAD) ? r_cnt : (w_rd ? r_ri : 10'd0);
   assign o_core_len    = r_len;
   assign o_core_clr    = r_clr | i_rst;
   assign o_m_valid     = (r_state == S_EMIT);
   assign o_m_data      = r_mdata;
   assign o_m_last      = r_mlast;
   assign o_busy        = (r_state != S_IDLE);
   assign o_err_timeout = r_eto;
   assign o_err_ovf     = r_eovf;

endmodule

// File: tb/tb_bwt_seq_ctrl.sv
// Bench for bwt_seq_ctrl: block-level reference model, a simple core model,
// directed cases from the feature list and a randomized stream.
module tb_bwt_seq_ctrl;

   localparam int ML = 8;
   localparam int TO = 16;

   logic       clk = 1'b0, rst = 1'b1;
   logic       s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b1;
   logic [7:0] s_data = 8'd0;
   logic       s_ready, m_valid, m_last, core_clr, core_en, core_done;
   logic       busy, err_timeout, err_ovf;
   logic [7:0] m_data, core_in;
   logic [7:0] core_out = 8'd0;
   logic [9:0] core_adr, core_len;

   bwt_seq_ctrl #(.MAX_LEN(ML), .SORT_TIMEOUT(TO)) dut (
      .i_clk(clk), .i_rst(rst), .i_s_valid(s_valid), .o_s_ready(s_ready),
      .i_s_data(s_data), .i_s_last(s_last), .o_m_valid(m_valid), .i_m_ready(m_ready),
      .o_m_data(m_data), .o_m_last(m_last), .o_core_clr(core_clr), .o_core_en(core_en),
      .o_core_adr(core_adr), .o_core_in(core_in), .o_core_len(core_len),
      .i_core_out(core_out), .i_core_done(core_done), .o_busy(busy),
      .o_err_timeout(err_timeout), .o_err_ovf(err_ovf));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Core model: byte store, registered read, done after `delay` idle cycles.
   logic [7:0] mem [0:1023];
   logic       loaded = 1'b0;
   int         dcnt = 0;
   int         delay = 1;
   bit         hang = 1'b0;
   bit         core_mode = 1'b0;
   int         mr_mode = 0;

   always @(posedge clk) begin
      if (core_en) mem[core_adr] <= core_in;
      core_out <= core_mode ? (mem[core_adr] ^ core_adr[7:0]) : (core_adr[7:0] + 8'h30);
      if (core_clr) begin
         loaded <= 1'b0;
         dcnt   <= 0;
      end else if (core_en) loaded <= 1'b1;
      else if (loaded) dcnt <= dcnt + 1;
   end
   assign core_done = !hang && loaded && !core_en && (dcnt >= delay);

   int nchk = 0, npass = 0;

   task automatic chk(input string nm, input int act, input int exp);
      nchk++;
      if (act == exp) npass++;
      else $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
   endtask

   task automatic finish_sim();
      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   endtask

   // Reference model: splits the accepted byte stream into blocks and predicts
   // every output byte, its last flag, the block length and the fault flags.
   typedef struct { logic [7:0] d; bit l; } ob_t;
   ob_t        exq[$];
   logic [7:0] cur[$];
   int         idx = 0, exp_len = 0, end_cyc = 0, clr_cnt = 0, last_hs_cyc = 0;
   bit         exp_ovf = 1'b0, to_pend = 1'b0;
   logic [7:0] log_d[$];
   bit         log_l[$], log_o[$];

   always @(negedge clk) begin
      if (rst) begin
         chk("clr_in_rst", core_clr, 1);
         cur.delete(); exq.delete();
         idx = 0; to_pend = 1'b0; clr_cnt = 0;
      end else begin
         if (core_clr) clr_cnt++;
         if (s_valid && s_ready) begin
            chk("core_en", core_en, 1);
            chk("core_adr_load", core_adr, idx);
            chk("core_in", core_in, s_data);
            cur.push_back(s_data);
            idx++;
            if (s_last || idx == ML) begin
               chk("clr_pulses", clr_cnt, 1);
               clr_cnt = 0;
               exp_ovf = !s_last;
               exp_len = idx;
               if (hang && idx > 1) begin
                  to_pend = 1'b1;
                  end_cyc = cyc;
               end else begin
                  for (int i = 0; i < idx; i++) begin
                     ob_t o;
                     o.d = core_mode ? (cur[i] ^ 8'(i)) : (8'(i) + 8'h30);
                     o.l = (i == idx - 1);
                     exq.push_back(o);
                  end
               end
               cur.delete();
               idx = 0;
            end
         end else begin
            chk("core_en_idle", core_en, 0);
         end
         if (to_pend && !busy) begin
            chk("timeout_cycles", cyc - end_cyc, TO + 1);
            chk("err_timeout_set", err_timeout, 1);
            to_pend = 1'b0;
         end
         if (m_valid) begin
            if (exq.size() == 0) chk("m_valid_unexpected", m_valid, 0);
            else begin
               chk("m_data", m_data, exq[0].d);
               chk("m_last", m_last, exq[0].l);
               chk("core_len", core_len, exp_len);
               chk("err_ovf", err_ovf, exp_ovf);
               chk("err_timeout_clr", err_timeout, 0);
               if (m_ready) begin
                  log_d.push_back(m_data);
                  log_l.push_back(m_last);
                  log_o.push_back(err_ovf);
                  if (m_last) last_hs_cyc = cyc;
                  void'(exq.pop_front());
               end
            end
         end
      end
   end

   initial forever begin
      @(posedge clk); #1;
      case (mr_mode)
         0: m_ready = 1'b1;
         1: m_ready = ~m_ready;
         default: m_ready = 1'($urandom_range(0, 1));
      endcase
   end

   logic [7:0] bd[$];
   bit         bl[$];
   int         t0 = 0;

   task automatic mk(input int n, input int lp);
      bd.delete(); bl.delete();
      for (int i = 0; i < n; i++) begin
         bd.push_back(8'($urandom));
         bl.push_back(i == lp);
      end
   endtask

   task automatic send(input int n, input int gapmax);
      for (int i = 0; i < n; i++) begin
         int g;
         bit hs;
         int w;
         g = (gapmax > 0) ? $urandom_range(0, gapmax) : 0;
         repeat (g) begin
            s_valid = 1'b0;
            @(posedge clk); #1;
         end
         if (i == 0) t0 = cyc;
         s_valid = 1'b1; s_data = bd[i]; s_last = bl[i];
         hs = 1'b0; w = 0;
         while (!hs) begin
            @(negedge clk);
            hs = s_ready;
            @(posedge clk); #1;
            w++;
            if (!hs && w > 400) begin
               chk("send_bound", 0, 1);
               finish_sim();
            end
         end
      end
      s_valid = 1'b0; s_last = 1'b0;
   endtask

   task automatic wait_idle();
      int w = 0;
      do begin
         @(negedge clk);
         w++;
      end while (busy && w < 600);
      if (busy) begin
         chk("idle_bound", busy, 0);
         finish_sim();
      end
      @(posedge clk); #1;
   endtask

   task automatic check_reset();
      chk("rst_s_ready", s_ready, 0);     chk("rst_m_valid", m_valid, 0);
      chk("rst_m_data", m_data, 0);       chk("rst_m_last", m_last, 0);
      chk("rst_core_en", core_en, 0);     chk("rst_core_adr", core_adr, 0);
      chk("rst_core_in", core_in, 0);     chk("rst_core_len", core_len, 0);
      chk("rst_busy", busy, 0);           chk("rst_err_timeout", err_timeout, 0);
      chk("rst_err_ovf", err_ovf, 0);     chk("rst_core_clr", core_clr, 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_reset();
      @(posedge clk); #1;

      // banana, core returns adr+0x30
      log_d.delete(); log_l.delete(); log_o.delete();
      bd = '{8'h62, 8'h61, 8'h6E, 8'h61, 8'h6E, 8'h61};
      bl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      send(6, 0);
      wait_idle();
      chk("banana_count", log_d.size(), 6);
      for (int i = 0; i < 6 && i < log_d.size(); i++) begin
         chk("banana_data", log_d[i], 8'h30 + i);
         chk("banana_last", log_l[i], (i == 5) ? 1 : 0);
      end
      chk("banana_len", core_len, 6);

      // single byte skips the sort
      core_mode = 1'b1;
      log_d.delete(); log_l.delete(); log_o.delete();
      bd = '{8'h41}; bl = '{1'b1};
      send(1, 0);
      wait_idle();
      chk("single_count", log_d.size(), 1);
      if (log_d.size() > 0) begin
         chk("single_data", log_d[0], 8'h41);
         chk("single_last", log_l[0], 1);
      end
      chk("single_len", core_len, 1);

      // sort timeout, then a clean block clears the flag
      hang = 1'b1;
      log_d.delete(); log_l.delete(); log_o.delete();
      mk(5, 4); send(5, 0); wait_idle();
      chk("to_flag", err_timeout, 1);
      chk("to_no_output", log_d.size(), 0);
      hang = 1'b0;
      mk(3, 2); send(3, 1); wait_idle();
      chk("to_cleared", err_timeout, 0);
      chk("after_to_count", log_d.size(), 3);

      // overflow: 10 bytes, last on 10th -> blocks of ML and 2
      log_d.delete(); log_l.delete(); log_o.delete();
      mk(10, 9); send(10, 0); wait_idle();
      chk("ovf_count", log_d.size(), 10);
      if (log_o.size() == 10) begin
         chk("ovf_first_blk", log_o[0], 1);
         chk("ovf_second_blk", log_o[9], 0);
      end
      chk("ovf_len2", core_len, 2);

      // exactly ML bytes with s_last is not an overflow
      mk(ML, ML - 1); send(ML, 0); wait_idle();
      chk("ml_exact_ovf", err_ovf, 0);
      chk("ml_exact_len", core_len, ML);

      // m_ready toggling during drain
      mr_mode = 1;
      log_d.delete(); log_l.delete(); log_o.delete();
      mk(6, 5); send(6, 0); wait_idle();
      chk("toggle_count", log_d.size(), 6);
      mr_mode = 0;

      // minimum latency: cycles first s_valid .. m_last handshake, inclusive
      delay = 0;
      @(posedge clk); #1;
      mk(4, 3); send(4, 0); wait_idle();
      chk("latency", last_hs_cyc - t0 + 1, 2 + 4 + 1 + 3 * 4);

      // reset on the 3rd load beat
      mk(5, 4); send(2, 0);
      s_valid = 1'b1; s_data = bd[2]; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; s_valid = 1'b0;
      @(negedge clk);
      check_reset();
      @(posedge clk); #1;
      log_d.delete(); log_l.delete(); log_o.delete();
      mk(3, 2); send(3, 0); wait_idle();
      chk("post_rst_count", log_d.size(), 3);

      // randomized blocks
      for (int k = 0; k < 25; k++) begin
         int n;
         core_mode = 1'($urandom_range(0, 1));
         delay     = $urandom_range(0, 3);
         hang      = ($urandom_range(0, 5) == 0);
         mr_mode   = 2;
         n         = $urandom_range(1, 12);
         mk(n, n - 1);
         send(n, 2);
         wait_idle();
      end
      hang = 1'b0;
      chk("rand_drained", exq.size(), 0);

      finish_sim();
   end

   initial begin
      #900000;
      chk("global_watchdog", 0, 1);
      finish_sim();
   end

endmodule
